// File: rtl/sparse_mult_sched_pkg.sv
// Shared constants and types for the sparse multiplier sequencer: operand sizes,
// FSM encoding and the dummy-position LFSR definition.
package sparse_mult_sched_pkg;

   localparam int N              = 17669;
   localparam int WEIGHT         = 66;
   localparam int MAX_WEIGHT     = 75;
   localparam int LOGW           = 16;
   localparam int LOGN           = 15;
   localparam int LOG_WEIGHT     = 7;
   localparam int LOG_MAX_WEIGHT = 7;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS      = 16'hB400;
   localparam logic [15:0] LFSR_ZERO_SEED = 16'hACE1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_e;

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[14:0], ^(l & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/sparse_mult_sched_if.sv
// Operation handshake between the sequencer (master) and the rotate/accumulate
// datapath (slave).
interface sparse_mult_sched_if
   import sparse_mult_sched_pkg::*;
   ();

   logic            op_valid;
   logic            op_ready;
   logic [LOGW-1:0] op_pos;
   logic            op_dummy;

   modport master (output op_valid, output op_pos, output op_dummy, input op_ready);
   modport slave  (input op_valid, input op_pos, input op_dummy, output op_ready);

endinterface

// File: rtl/dummy_pos_gen.sv
// LFSR-driven dummy position source; the low LOGN bits are folded into [0, N).
module dummy_pos_gen
   import sparse_mult_sched_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_i,
   input  logic [15:0]     seed_i,
   input  logic            step_i,
   output logic [LOGW-1:0] pos_o
);

   logic [15:0]     lfsr_q;
   logic [15:0]     lfsr_d;
   logic [LOGW-1:0] raw;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = (seed_i == 16'h0) ? LFSR_ZERO_SEED : seed_i;
      end else if (step_i) begin
         lfsr_d = lfsr_next(lfsr_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= LFSR_ZERO_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   // 2^LOGN < 2N, so a single conditional subtract is a full reduction.
   always_comb begin
      raw   = {{(LOGW-LOGN){1'b0}}, lfsr_q[LOGN-1:0]};
      pos_o = (raw >= LOGW'(N)) ? (raw - LOGW'(N)) : raw;
   end

endmodule

// File: rtl/mem_single.sv
// Single-port position RAM with one-cycle registered read.
module mem_single #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 66,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  din,
   output logic [WIDTH-1:0]  dout
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Writes beyond the stored depth are dropped rather than aliased.
   always_ff @(posedge clk) begin
      if (we && (addr < ADDR_W'(DEPTH))) begin
         mem[addr] <= din;
      end
      dout <= mem[addr];
   end

endmodule

// File: rtl/sparse_mult_sched.sv
// Sparse multiplier sequencer: every slot is FETCH+ISSUE regardless of being real
// or dummy, so the operation stream timing is independent of the dummy bitmap.
module sparse_mult_sched
   import sparse_mult_sched_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic [LOG_WEIGHT-1:0] addr_i,
   input  logic [LOGW-1:0]       pos_i,
   input  logic                  start_i,
   input  logic [MAX_WEIGHT-1:0] dmask_i,
   input  logic [15:0]           seed_i,
   input  logic                  dp_idle_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   sparse_mult_sched_if.master   op_if
);

   state_e                    state_q, state_d;
   logic [LOG_MAX_WEIGHT-1:0] slot_q, slot_d;
   logic [LOG_WEIGHT-1:0]     real_cnt_q, real_cnt_d;
   logic [MAX_WEIGHT-1:0]     dmask_q, dmask_d;
   logic                      flag_q, flag_d;
   logic                      op_valid_q, op_valid_d;
   logic [LOGW-1:0]           op_pos_q, op_pos_d;
   logic                      op_dummy_q, op_dummy_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;

   logic                      ram_we;
   logic [LOG_WEIGHT-1:0]     ram_addr;
   logic [LOGW-1:0]           ram_q;
   logic                      lfsr_load;
   logic                      lfsr_step;
   logic [LOGW-1:0]           dummy_pos;
   logic                      slot_dummy;

   mem_single #(.WIDTH(LOGW), .DEPTH(WEIGHT), .ADDR_W(LOG_WEIGHT)) POSITION_RAM (
      .clk  (clk),
      .we   (ram_we),
      .addr (ram_addr),
      .din  (pos_i),
      .dout (ram_q)
   );

   dummy_pos_gen u_dummy_pos_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (lfsr_load),
      .seed_i (seed_i),
      .step_i (lfsr_step),
      .pos_o  (dummy_pos)
   );

   // The read address tracks the next real count so RAM q is ready during FETCH
   // and can be registered straight into op_pos for ISSUE.
   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      real_cnt_d = real_cnt_q;
      dmask_d    = dmask_q;
      flag_d     = flag_q;
      op_valid_d = op_valid_q;
      op_pos_d   = op_pos_q;
      op_dummy_d = op_dummy_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      ram_we     = 1'b0;
      lfsr_load  = 1'b0;
      lfsr_step  = 1'b0;
      slot_dummy = dmask_q[slot_q] || (real_cnt_q >= LOG_WEIGHT'(WEIGHT));

      case (state_q)
         S_IDLE: begin
            if (load_i) begin
               ram_we = 1'b1;
            end else if (start_i) begin
               dmask_d    = dmask_i;
               slot_d     = '0;
               real_cnt_d = '0;
               flag_d     = 1'b0;
               err_d      = 1'b0;
               busy_d     = 1'b1;
               lfsr_load  = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_FETCH: begin
            op_valid_d = 1'b1;
            op_dummy_d = slot_dummy;
            op_pos_d   = slot_dummy ? dummy_pos : ram_q;
            if (!dmask_q[slot_q] && (real_cnt_q >= LOG_WEIGHT'(WEIGHT))) begin
               flag_d = 1'b1;
            end
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (op_if.op_ready) begin
               op_valid_d = 1'b0;
               slot_d     = slot_q + LOG_MAX_WEIGHT'(1);
               if (op_dummy_q) begin
                  lfsr_step = 1'b1;
               end else begin
                  real_cnt_d = real_cnt_q + LOG_WEIGHT'(1);
               end
               state_d = (slot_q == LOG_MAX_WEIGHT'(MAX_WEIGHT - 1)) ? S_DRAIN : S_FETCH;
            end
         end
         S_DRAIN: begin
            if (dp_idle_i) begin
               done_d  = 1'b1;
               err_d   = flag_q || (real_cnt_q != LOG_WEIGHT'(WEIGHT));
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_q == S_IDLE && load_i) begin
         ram_addr = addr_i;
      end else if (real_cnt_d >= LOG_WEIGHT'(WEIGHT)) begin
         ram_addr = LOG_WEIGHT'(WEIGHT - 1);
      end else begin
         ram_addr = real_cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         slot_q     <= '0;
         real_cnt_q <= '0;
         dmask_q    <= '0;
         flag_q     <= 1'b0;
         op_valid_q <= 1'b0;
         op_pos_q   <= '0;
         op_dummy_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         real_cnt_q <= real_cnt_d;
         dmask_q    <= dmask_d;
         flag_q     <= flag_d;
         op_valid_q <= op_valid_d;
         op_pos_q   <= op_pos_d;
         op_dummy_q <= op_dummy_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign op_if.op_valid = op_valid_q;
   assign op_if.op_pos   = op_pos_q;
   assign op_if.op_dummy = op_dummy_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign err_o          = err_q;

endmodule

// File: tb/tb_sparse_mult_sched.sv
// Self-checking bench for sparse_mult_sched: a slot-level schedule model feeds an
// expected-operation queue that a single compare process checks on every handshake.
module tb_sparse_mult_sched;
   import sparse_mult_sched_pkg::*;

   logic                  clk       = 1'b0;
   logic                  rst_n     = 1'b0;
   logic                  load_i    = 1'b0;
   logic [LOG_WEIGHT-1:0] addr_i    = '0;
   logic [LOGW-1:0]       pos_i     = '0;
   logic                  start_i   = 1'b0;
   logic [MAX_WEIGHT-1:0] dmask_i   = '0;
   logic [15:0]           seed_i    = '0;
   logic                  dp_idle_i = 1'b1;
   logic                  busy_o;
   logic                  done_o;
   logic                  err_o;

   sparse_mult_sched_if op_if ();

   sparse_mult_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load_i),
      .addr_i    (addr_i),
      .pos_i     (pos_i),
      .start_i   (start_i),
      .dmask_i   (dmask_i),
      .seed_i    (seed_i),
      .dp_idle_i (dp_idle_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .err_o     (err_o),
      .op_if     (op_if)
   );

   always #5 clk = ~clk;

   int          cmp_count  = 0;
   int          fail_count = 0;
   logic [15:0] exp_pos_q[$];
   logic        exp_dummy_q[$];
   logic [15:0] ram_model[WEIGHT];
   bit          backpressure = 1'b0;
   int          acc_cnt = 0;
   logic [15:0] got_pos[MAX_WEIGHT];
   logic        got_dummy[MAX_WEIGHT];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      cmp_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Schedule model: walk the slots, taking RAM entries in order for real slots
   // and LFSR-derived positions for dummy or overflowing real slots.
   function automatic void build_expected(input logic [MAX_WEIGHT-1:0] dm, input logic [15:0] sd,
                                          output logic exp_err);
      logic [15:0] l;
      int          rc;
      bit          flag;
      int          r;
      l    = (sd == 16'h0) ? 16'hACE1 : sd;
      rc   = 0;
      flag = 0;
      exp_pos_q.delete();
      exp_dummy_q.delete();
      for (int s = 0; s < MAX_WEIGHT; s++) begin
         if (dm[s] || rc >= WEIGHT) begin
            r = int'(l[14:0]);
            exp_pos_q.push_back(16'((r >= N) ? r - N : r));
            exp_dummy_q.push_back(1'b1);
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            if (!dm[s]) flag = 1;
         end else begin
            exp_pos_q.push_back(ram_model[rc]);
            exp_dummy_q.push_back(1'b0);
            rc++;
         end
      end
      exp_err = flag || (rc != WEIGHT);
   endfunction

   // Ready pattern: low one cycle in three under backpressure, so stalls recur.
   initial begin
      int rcyc;
      rcyc = 0;
      op_if.op_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         rcyc++;
         op_if.op_ready = backpressure ? ((rcyc % 3) != 0) : 1'b1;
      end
   end

   // Compare process: every accepted op against the model, every stall for stability.
   initial begin
      bit          stall_prev;
      logic [15:0] held_pos;
      logic        held_dummy;
      stall_prev = 0;
      held_pos   = '0;
      held_dummy = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n || !op_if.op_valid) begin
            stall_prev = 0;
         end else begin
            if (stall_prev) begin
               checkOutput("stall_pos", op_if.op_pos, held_pos);
               checkOutput("stall_dummy", op_if.op_dummy, held_dummy);
            end
            if (op_if.op_ready) begin
               if (exp_pos_q.size() == 0) begin
                  checkOutput("unexpected_op", 1, 0);
               end else begin
                  checkOutput("op_pos", op_if.op_pos, exp_pos_q.pop_front());
                  checkOutput("op_dummy", op_if.op_dummy, exp_dummy_q.pop_front());
               end
               if (acc_cnt < MAX_WEIGHT) begin
                  got_pos[acc_cnt]   = op_if.op_pos;
                  got_dummy[acc_cnt] = op_if.op_dummy;
               end
               acc_cnt++;
               stall_prev = 0;
            end else begin
               stall_prev = 1;
               held_pos   = op_if.op_pos;
               held_dummy = op_if.op_dummy;
            end
         end
      end
   end

   task automatic startRun(input logic [MAX_WEIGHT-1:0] dm, input logic [15:0] sd, output logic exp_err);
      build_expected(dm, sd, exp_err);
      acc_cnt = 0;
      @(negedge clk);
      dmask_i = dm;
      seed_i  = sd;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      checkOutput("busy_rise", busy_o, 1);
   endtask

   task automatic applyStimulus(input logic [MAX_WEIGHT-1:0] dm, input logic [15:0] sd, input bit bp,
                                input int exp_cycles, input bit mid_load);
      logic exp_err;
      int   cycles;
      bit   seen;
      backpressure = bp;
      startRun(dm, sd, exp_err);
      cycles = 1;
      seen   = 0;
      while (!seen && cycles < 5000) begin
         if (mid_load && cycles == 3) begin
            load_i = 1'b1;
            addr_i = 7'd5;
            pos_i  = 16'd999;
         end
         if (mid_load && cycles == 6) load_i = 1'b0;
         @(posedge clk);
         #1;
         cycles++;
         if (done_o) seen = 1;
      end
      checkOutput("done_seen", seen, 1);
      if (exp_cycles > 0) checkOutput("done_cycle", cycles, exp_cycles);
      checkOutput("err_at_done", err_o, exp_err);
      checkOutput("ops_issued", acc_cnt, MAX_WEIGHT);
      checkOutput("busy_at_done", busy_o, 1);
      @(posedge clk);
      #1;
      checkOutput("done_one_cycle", done_o, 0);
      checkOutput("busy_fall", busy_o, 0);
      checkOutput("err_held", err_o, exp_err);
      backpressure = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [MAX_WEIGHT-1:0] m_tail, m_nine, m_ten, m_eight;
      logic                  e;
      int                    waitc;

      for (int s = 0; s < MAX_WEIGHT; s++) begin
         m_tail[s]  = (s >= WEIGHT);
         m_nine[s]  = (s % 9 == 0);
         m_ten[s]   = (s % 8 == 0);
         m_eight[s] = (s % 10 == 0);
      end

      repeat (3) @(negedge clk);
      checkOutput("rst_valid", op_if.op_valid, 0);
      checkOutput("rst_pos", op_if.op_pos, 0);
      checkOutput("rst_dummy", op_if.op_dummy, 0);
      checkOutput("rst_busy", busy_o, 0);
      checkOutput("rst_done", done_o, 0);
      checkOutput("rst_err", err_o, 0);
      rst_n = 1'b1;

      for (int a = 0; a < WEIGHT; a++) begin
         @(negedge clk);
         load_i = 1'b1;
         addr_i = 7'(a);
         pos_i  = 16'(3 * a);
         ram_model[a] = 16'(3 * a);
      end
      @(negedge clk);
      load_i = 1'b0;

      $display("[TB] run 1: 66 reals then 9 dummies, no backpressure");
      applyStimulus(m_tail, 16'hACE1, 1'b0, 152, 1'b0);
      checkOutput("lit_first_real", got_pos[0], 0);
      checkOutput("lit_last_real", got_pos[65], 195);
      checkOutput("lit_first_dummy", got_pos[66], 11489);
      checkOutput("lit_second_dummy", got_pos[67], 5310);
      checkOutput("lit_dummy_flag", got_dummy[66], 1);

      $display("[TB] run 2: interleaved dummies, backpressure, load while busy");
      applyStimulus(m_nine, 16'h1357, 1'b1, 0, 1'b1);
      checkOutput("lit_slot0_dummy", got_dummy[0], 1);
      checkOutput("lit_slot1_pos", got_pos[1], 0);
      checkOutput("lit_slot10_pos", got_pos[10], 24);

      $display("[TB] run 3: ten dummies");
      applyStimulus(m_ten, 16'h1234, 1'b0, 152, 1'b0);
      checkOutput("lit_err_65_reals", err_o, 1);

      $display("[TB] run 4: eight dummies");
      applyStimulus(m_eight, 16'h00FF, 1'b0, 152, 1'b0);
      checkOutput("lit_err_67_reals", err_o, 1);
      checkOutput("lit_overflow_dummy", got_dummy[74], 1);

      $display("[TB] run 5: zero seed");
      applyStimulus(m_tail, 16'h0000, 1'b0, 152, 1'b0);
      checkOutput("lit_zero_seed_dummy", got_pos[66], 11489);

      $display("[TB] run 6: reset at slot 20, then rerun");
      startRun(m_tail, 16'hACE1, e);
      waitc = 0;
      while (acc_cnt < 20 && waitc < 1000) begin
         @(posedge clk);
         waitc++;
      end
      checkOutput("reach_slot20", (acc_cnt >= 20), 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_valid", op_if.op_valid, 0);
      checkOutput("async_rst_pos", op_if.op_pos, 0);
      checkOutput("async_rst_busy", busy_o, 0);
      checkOutput("async_rst_done", done_o, 0);
      checkOutput("async_rst_err", err_o, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(m_tail, 16'hACE1, 1'b0, 152, 1'b0);
      checkOutput("lit_ram5_kept", got_pos[5], 15);
      checkOutput("lit_slot20_pos", got_pos[20], 60);

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
      $finish;
   end

endmodule
